// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// -----------------------------------------------------------------------------
// Shares one physical memory port between the I-cache and the D-cache.
// One line transaction (read or write) is granted at a time; the grant is held
// until memory answers with pmem_resp, and one IDLE cycle always separates two
// grants so memory sees its strobes drop between transactions.
//
// Handshake: a cache holds x_pmem_read/x_pmem_write (and address/wdata) until
// it sees x_pmem_resp for one cycle; memory holds nothing and answers with a
// single-cycle pmem_resp while granted. rdata is broadcast; resp qualifies it.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : on a tie the side not granted last wins (pointer resets to I,
//               so D wins the first tie)
//   undefined : D always wins ties; no pointer register exists
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   i_pmem_* / d_pmem_*         cache-side request (read, write, address,
//                               wdata in) and response (rdata, resp out)
//   pmem_read/write/address/wdata  strobes and data toward memory
//   pmem_rdata, pmem_resp       memory read line and completion pulse
//   arb_state                   debug view of the FSM (0 IDLE, 1 GRANT_I,
//                               2 GRANT_D)
// -----------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_pmem_read,
    input  logic                  i_pmem_write,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    input  logic [LINE_WIDTH-1:0] i_pmem_wdata,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic [1:0]            arb_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic i_req;
    logic d_req;
    logic pick_d;

    assign i_req = i_pmem_read | i_pmem_write;
    assign d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 when D held the most recent grant. Only consulted on a tie.
    logic last_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_d <= 1'b0;
        end else if (state == IDLE && state_next != IDLE) begin
            last_d <= (state_next == GRANT_D);
        end
    end

    assign pick_d = d_req & (~i_req | ~last_d);
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pick_d) begin
                    state_next = GRANT_D;
                end else if (i_req) begin
                    state_next = GRANT_I;
                end
            end
            // The grant is held until memory answers, even if the cache
            // drops its request in the meantime.
            GRANT_I, GRANT_D: begin
                if (pmem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        case (state)
            GRANT_I: begin
                pmem_read    = i_pmem_read;
                pmem_write   = i_pmem_write;
                pmem_address = i_pmem_address;
                pmem_wdata   = i_pmem_wdata;
                i_pmem_resp  = pmem_resp;
            end
            GRANT_D: begin
                pmem_read    = d_pmem_read;
                pmem_write   = d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp;
            end
            default: ;
        endcase
    end

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;
    assign arb_state    = state;

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Two-port physical-memory arbiter between the instruction cache and the data cache. It sits between the `pmem_*` ports of the two cache controllers and the single physical memory port. It grants one cache line transaction (read or write) at a time and holds the grant until memory responds. It routes the response only to the granted cache and inserts one idle turnaround cycle between transactions.

## Interface
- `ADDR_WIDTH`, 16, byte address width (lc3b word).
- `LINE_WIDTH`, 128, cache line width in bits.

- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `i_pmem_read`  in  1  I-cache line read request.
- `i_pmem_write`  in  1  I-cache line write request; always 0 in practice, still arbitrated.
- `i_pmem_address`  in  ADDR_WIDTH  I-cache line address.
- `i_pmem_wdata`  in  LINE_WIDTH  I-cache write line.
- `i_pmem_rdata`  out  LINE_WIDTH  read line to I-cache.
- `i_pmem_resp`  out  1  completion pulse to I-cache.
- `d_pmem_read`, `d_pmem_write`, `d_pmem_address`, `d_pmem_wdata`, `d_pmem_rdata`, `d_pmem_resp`: same as the I-side, for the D-cache.
- `pmem_read`  out  1  read strobe to physical memory.
- `pmem_write`  out  1  write strobe to physical memory.
- `pmem_address`  out  ADDR_WIDTH  address to memory.
- `pmem_wdata`  out  LINE_WIDTH  write line to memory.
- `pmem_rdata`  in  LINE_WIDTH  read line from memory.
- `pmem_resp`  in  1  memory completion, 1-cycle pulse.

## Operation
- States: `IDLE`, `GRANT_I`, `GRANT_D`.
- Request from a side: `x_pmem_read | x_pmem_write`.
- `IDLE`:
  - All `pmem_*` outputs are 0.
  - If any request is present, the winner is chosen and the next state is `GRANT_<winner>`. Otherwise stay in `IDLE`.
- Winner selection:
  - Only one side requesting: that side wins.
  - Both requesting: the default is fixed D-priority. See Configuration for the round-robin option.
- `GRANT_x`:
  - `pmem_read`, `pmem_write`, `pmem_address` and `pmem_wdata` are driven combinationally from side x.
  - `x_pmem_resp = pmem_resp`. The other side's resp is 0.
  - When `pmem_resp` = 1, the next state is `IDLE`. Otherwise stay in the current state.
- The grant is never revoked before `pmem_resp`, even if side x drops its request. This is a protocol violation: flag it in a bench assertion. The RTL keeps forwarding side x's current (possibly 0) strobes.
- `i_pmem_rdata` and `d_pmem_rdata` both equal `pmem_rdata` at all times (broadcast). The resp gating alone qualifies the data.
- `pmem_resp` arriving in `IDLE` is ignored: no resp goes to either cache.
- Any `pmem_read & pmem_write` combination from the granted cache is forwarded unmodified. The arbiter performs no checking.

## Timing
- Reset (`rst_n` = 0 at a rising edge):
  - State goes to `IDLE`; the last-grant pointer goes to I.
  - `pmem_read`, `pmem_write`, `pmem_address`, `pmem_wdata`, `i_pmem_resp` and `d_pmem_resp` are all 0 from the following cycle.
  - Reset mid-grant abandons the transaction. No resp is forwarded.
- Grant latency: a request seen in `IDLE` at edge N drives the memory strobes in cycle N+1. The minimum is 1 cycle of arbitration latency.
- Completion: with `pmem_resp` in cycle M, the cache sees resp in the same cycle M (combinational) and the state is `IDLE` in cycle M+1.
- Turnaround: there is exactly one `IDLE` cycle between back-to-back grants. A cache holding its request continuously (writeback followed by fill) re-arbitrates in that cycle.
- Memory strobes are never asserted in `IDLE`, so memory sees at least one deasserted cycle between transactions.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - On a simultaneous request, the side not granted last wins.
  - The last-grant pointer updates on every `IDLE` to `GRANT_x` transition.
  - After reset the pointer is I, so D wins the first tie.
- `ARB_ROUND_ROBIN_EN` undefined:
  - D always wins ties.
  - The pointer register is not built.
  - The I-side can be starved by a continuously requesting D-cache.

## Test plan
- Single I read: `i_pmem_read`=1, address 0x1230, memory resp after 4 cycles with rdata 0xA5…A5 -> `pmem_read`=1 and `pmem_address`=0x1230 from cycle 1. `i_pmem_resp` pulses in exactly one cycle with `i_pmem_rdata`=0xA5…A5. `d_pmem_resp` stays 0.
- Simultaneous I read (0x0040) and D write (0x8000, wdata 0xDEAD…): D is served first (`pmem_write`=1, address 0x8000). Then one `IDLE` cycle, then the I read (`pmem_read`=1, 0x0040). Each cache gets exactly one resp.
- D writeback then fill: `d_pmem_write` to 0x2000, then `d_pmem_read` to 0x3000 with no gap, while I requests 0x0100 throughout. Without the macro, D's read is granted before I. With `ARB_ROUND_ROBIN_EN`, I is granted before D's read.
- Reset mid-grant: assert `rst_n`=0 in cycle 2 of a D read -> next cycle all outputs are 0 and the state is `IDLE`. A later `pmem_resp` pulse produces no cache resp.
- Stray `pmem_resp` in `IDLE` with no requests -> both cache resps remain 0 and the state stays `IDLE`.
- Request dropped mid-grant: I deasserts after 1 cycle of grant -> the grant is held until `pmem_resp`. There is no switch to a pending D request before then.
